// File: rtl/guvm_mem_pkg.sv
// guvm_mem_pkg: shared constants and response type for the data-memory responder
package guvm_mem_pkg;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

    localparam int RESP_LATENCY_MIN    = 1;
    localparam int RESP_LATENCY_MAX    = 8;
    localparam int MAX_OUTSTANDING_MIN = 1;
    localparam int MAX_OUTSTANDING_MAX = 8;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_resp_t;

    function automatic bit in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/guvm_resp_pipe.sv
// guvm_resp_pipe: fixed-depth valid+response shift pipeline; the last stage holds its payload between responses
module guvm_resp_pipe
    import guvm_mem_pkg::*;
#(
    parameter int RESP_LATENCY = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       in_valid_i,
    input  dmem_resp_t in_resp_i,
    output logic       out_valid_o,
    output dmem_resp_t out_resp_o
);

    logic [RESP_LATENCY-1:0] r_valid;
    dmem_resp_t              r_resp [RESP_LATENCY];

    // shift valids every cycle; payload only moves with a valid so the output stage holds its last response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            for (int i = 0; i < RESP_LATENCY; i++) r_resp[i] <= '0;
        end else begin
            r_valid[0] <= in_valid_i;
            if (in_valid_i) r_resp[0] <= in_resp_i;
            for (int i = 1; i < RESP_LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                if (r_valid[i-1]) r_resp[i] <= r_resp[i-1];
            end
        end
    end

    assign out_valid_o = r_valid[RESP_LATENCY-1];
    assign out_resp_o  = r_resp[RESP_LATENCY-1];

endmodule

// File: rtl/guvm_data_mem_responder.sv
// guvm_data_mem_responder: req/gnt/rvalid data-memory slave with byte-enabled word array; GUVM_DMEM_RAND_STALL_EN adds LFSR grant stalls
module guvm_data_mem_responder
    import guvm_mem_pkg::*;
#(
    parameter int          MEM_DEPTH_WORDS = 1024,
    parameter int          RESP_LATENCY    = 1,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int AW = $clog2(MEM_DEPTH_WORDS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    if (!in_range(RESP_LATENCY, RESP_LATENCY_MIN, RESP_LATENCY_MAX) ||
        !in_range(MAX_OUTSTANDING, MAX_OUTSTANDING_MIN, MAX_OUTSTANDING_MAX) ||
        MEM_DEPTH_WORDS < 4 || (MEM_DEPTH_WORDS & (MEM_DEPTH_WORDS - 1)) != 0 ||
        LFSR_SEED == 16'h0) begin : g_bad_param
        $error("guvm_data_mem_responder: illegal parameter value");
    end

    logic [31:0]   r_mem [MEM_DEPTH_WORDS];
    logic [CW-1:0] r_cnt;
    logic          w_stall;
    logic          w_oor;
    logic          w_rvalid;
    logic [AW-1:0] w_idx;
    dmem_resp_t    w_resp;
    dmem_resp_t    w_out;

    assign w_idx = data_addr_i[AW+1:2];
    assign w_oor = data_addr_i >= 32'(4 * MEM_DEPTH_WORDS);

    // a response leaving this cycle frees its slot, so a full counter can still grant alongside it
    assign data_gnt_o = data_req_i && ((r_cnt - CW'(w_rvalid)) < CW'(MAX_OUTSTANDING)) && !w_stall && rst_ni;

    // response captured at the grant edge; reads see every write granted in an earlier cycle
    always_comb begin
        w_resp.rdata = w_oor ? ERR_RDATA : (data_we_i ? 32'h0 : r_mem[w_idx]);
        w_resp.err   = w_oor;
    end

    // byte-enabled write on an in-range granted write; contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (data_gnt_o && data_we_i && !w_oor)
            for (int i = 0; i < 4; i++)
                if (data_be_i[i]) r_mem[w_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
    end

    // granted-but-unanswered request count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_cnt <= '0;
        else         r_cnt <= r_cnt + CW'(data_gnt_o) - CW'(w_rvalid);
    end

`ifdef GUVM_DMEM_RAND_STALL_EN
    logic [15:0] r_lfsr;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_lfsr <= LFSR_SEED;
        else         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    guvm_resp_pipe #(
        .RESP_LATENCY(RESP_LATENCY)
    ) u_pipe (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (data_gnt_o),
        .in_resp_i  (w_resp),
        .out_valid_o(w_rvalid),
        .out_resp_o (w_out)
    );

    assign data_rvalid_o = w_rvalid;
    assign data_rdata_o  = w_out.rdata;
    assign data_err_o    = w_out.err;

endmodule

// File: tb/tb_guvm_data_mem_responder.sv
// tb_guvm_data_mem_responder: directed and randomized checks of the data-memory responder against a queue/array model
module tb_guvm_data_mem_responder;

    localparam int LAT_A = 1, MAX_A = 2;
    localparam int LAT_B = 4, MAX_B = 2;

    logic        clk = 1'b0;
    logic        rst_na, rst_nb, req_a, req_b, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        gnt_a, gnt_b, rv_a, rv_b, err_a, err_b;
    logic [31:0] rd_a, rd_b;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic        w;
        logic [3:0]  b;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        e;
    } op_t;

    always #5 clk = ~clk;

    guvm_data_mem_responder #(.MEM_DEPTH_WORDS(1024), .RESP_LATENCY(LAT_A), .MAX_OUTSTANDING(MAX_A)) dut_a (
        .clk_i(clk), .rst_ni(rst_na), .data_req_i(req_a), .data_gnt_o(gnt_a), .data_we_i(we),
        .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata), .data_rvalid_o(rv_a),
        .data_rdata_o(rd_a), .data_err_o(err_a));

    guvm_data_mem_responder #(.MEM_DEPTH_WORDS(1024), .RESP_LATENCY(LAT_B), .MAX_OUTSTANDING(MAX_B)) dut_b (
        .clk_i(clk), .rst_ni(rst_nb), .data_req_i(req_b), .data_gnt_o(gnt_b), .data_we_i(we),
        .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata), .data_rvalid_o(rv_b),
        .data_rdata_o(rd_b), .data_err_o(err_b));

`ifdef GUVM_DMEM_RAND_STALL_EN
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_na)
        if (!rst_na) m_lfsr <= 16'hACE1;
        else         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_a(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d, output bit ok);
        req_a = 1'b1; we = w; be = b; addr = a; wdata = d; ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = gnt_a;
            step();
        end
        req_a = 1'b0;
    endtask

    task automatic xfer_a(input op_t o, output bit ok, output logic rv, output logic [31:0] rd, output logic er);
        issue_a(o.w, o.b, o.a, o.d, ok);
        @(negedge clk);
        rv = rv_a; rd = rd_a; er = err_a;
        step();
    endtask

    task automatic test_reset();
        rst_na = 1'b0; rst_nb = 1'b0; req_a = 1'b1; req_b = 1'b1;
        we = 1'b1; be = 4'h0; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (gnt_a !== 1'b0) $display("FAIL reset_gnt_a: got %b expected 0", gnt_a); else n_pass++;
        n_total++; if (gnt_b !== 1'b0) $display("FAIL reset_gnt_b: got %b expected 0", gnt_b); else n_pass++;
        n_total++; if (rv_a !== 1'b0) $display("FAIL reset_rvalid: got %b expected 0", rv_a); else n_pass++;
        n_total++; if (rd_a !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", rd_a); else n_pass++;
        n_total++; if (err_a !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_a); else n_pass++;
        n_total++; if (rv_b !== 1'b0) $display("FAIL reset_rvalid_b: got %b expected 0", rv_b); else n_pass++;
        req_b = 1'b0;
        step();
        rst_na = 1'b1; rst_nb = 1'b1;
        @(negedge clk);
        n_total++; if (gnt_a !== 1'b1) $display("FAIL first_gnt: got %b expected 1", gnt_a); else n_pass++;
        step();
        req_a = 1'b0;
        @(negedge clk);
        n_total++; if (rv_a !== 1'b1 || err_a !== 1'b0) $display("FAIL noop_write_resp: got rv=%b err=%b expected 1/0", rv_a, err_a); else n_pass++;
        step();
    endtask

    task automatic test_write_read();
        op_t t [7] = '{
            '{1'b1, 4'hF, 32'h10, 32'h1122_3344, 32'h0,         1'b0},
            '{1'b0, 4'hF, 32'h10, 32'h0,         32'h1122_3344, 1'b0},
            '{1'b1, 4'h5, 32'h10, 32'hAABB_CCDD, 32'h0,         1'b0},
            '{1'b0, 4'h0, 32'h13, 32'h0,         32'h11BB_33DD, 1'b0},
            '{1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF, 32'h0,         1'b0},
            '{1'b0, 4'hF, 32'h10, 32'h0,         32'h11BB_33DD, 1'b0},
            '{1'b1, 4'hA, 32'h11, 32'h5566_7788, 32'h0,         1'b0}};
        bit ok; logic rv, er; logic [31:0] rd;
        for (int i = 0; i < 7; i++) begin
            xfer_a(t[i], ok, rv, rd, er);
            n_total++; if (!ok) $display("FAIL wr_gnt[%0d]: no grant within bound", i); else n_pass++;
            n_total++; if (rv !== 1'b1 || rd !== t[i].rd || er !== t[i].e)
                $display("FAIL wr_resp[%0d]: got rv=%b rdata=%h err=%b expected 1 %h %b", i, rv, rd, er, t[i].rd, t[i].e);
            else n_pass++;
        end
        xfer_a('{1'b0, 4'hF, 32'h10, 32'h0, 32'h0, 1'b0}, ok, rv, rd, er);
        n_total++; if (rd !== 32'h55BB_77DD) $display("FAIL wr_be1010: got %h expected 55bb77dd", rd); else n_pass++;
        @(negedge clk);
        n_total++; if (rv_a !== 1'b0 || rd_a !== 32'h55BB_77DD)
            $display("FAIL hold: got rv=%b rdata=%h expected 0 55bb77dd", rv_a, rd_a);
        else n_pass++;
        step();
    endtask

    task automatic test_oor();
        op_t t [7] = '{
            '{1'b1, 4'hF, 32'h0,         32'hCAFE_F00D, 32'h0,         1'b0},
            '{1'b1, 4'hF, 32'h1000,      32'h1234_5678, 32'hDEAD_BEEF, 1'b1},
            '{1'b0, 4'hF, 32'h1000,      32'h0,         32'hDEAD_BEEF, 1'b1},
            '{1'b0, 4'hF, 32'h0,         32'h0,         32'hCAFE_F00D, 1'b0},
            '{1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0,         32'hDEAD_BEEF, 1'b1},
            '{1'b1, 4'hF, 32'hFFC,       32'h5A5A_A5A5, 32'h0,         1'b0},
            '{1'b0, 4'hF, 32'hFFF,       32'h0,         32'h5A5A_A5A5, 1'b0}};
        bit ok; logic rv, er; logic [31:0] rd;
        for (int i = 0; i < 7; i++) begin
            xfer_a(t[i], ok, rv, rd, er);
            n_total++; if (!ok || rv !== 1'b1 || rd !== t[i].rd || er !== t[i].e)
                $display("FAIL oor[%0d]: got ok=%b rv=%b rdata=%h err=%b expected 1 1 %h %b", i, ok, rv, rd, er, t[i].rd, t[i].e);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] mem [16];
        exp_t q[$];
        exp_t e;
        bit ok, now, exp_g, oor;
        logic rv, er; logic [31:0] rd;
        for (int k = 0; k < 16; k++) begin
            e.rdata = $urandom;
            xfer_a('{1'b1, 4'hF, 32'(k * 4), e.rdata, 32'h0, 1'b0}, ok, rv, rd, er);
            n_total++; if (!ok) $display("FAIL rnd_preload[%0d]: no grant within bound", k); else n_pass++;
            mem[k] = e.rdata;
        end
        for (int c = 0; c < 600; c++) begin
            req_a = (c < 590) && ($urandom % 4 != 0);
            we = 1'($urandom); be = 4'($urandom); wdata = $urandom;
            addr = ($urandom % 8 == 0) ? 32'h1000 + ($urandom % 32'hFFFF_E000) : 32'(($urandom % 16) * 4 + $urandom % 4);
            @(negedge clk);
            now = q.size() > 0 && q[0].due == c;
            exp_g = req_a && (q.size() - int'(now)) < MAX_A;
`ifdef GUVM_DMEM_RAND_STALL_EN
            exp_g = exp_g && (m_lfsr[1:0] != 2'b00);
`endif
            n_total++; if (gnt_a !== exp_g) $display("FAIL rnd_gnt@%0d: got %b expected %b", c, gnt_a, exp_g); else n_pass++;
            n_total++; if (rv_a !== now) $display("FAIL rnd_rvalid@%0d: got %b expected %b", c, rv_a, now); else n_pass++;
            if (now) begin
                n_total++; if (rd_a !== q[0].rdata || err_a !== q[0].err)
                    $display("FAIL rnd_resp@%0d: got %h/%b expected %h/%b", c, rd_a, err_a, q[0].rdata, q[0].err);
                else n_pass++;
                void'(q.pop_front());
            end
            if (gnt_a) begin
                oor = addr >= 32'h1000;
                e.due = c + LAT_A;
                e.err = oor;
                e.rdata = oor ? 32'hDEAD_BEEF : (we ? 32'h0 : mem[addr[5:2]]);
                q.push_back(e);
                if (we && !oor)
                    for (int k = 0; k < 4; k++) if (be[k]) mem[addr[5:2]][8*k +: 8] = wdata[8*k +: 8];
            end
            step();
        end
        req_a = 1'b0;
    endtask

    task automatic test_lat4();
`ifndef GUVM_DMEM_RAND_STALL_EN
        logic [31:0] mb [4];
        exp_t q[$];
        exp_t e;
        bit now;
        int p = 0;
        for (int k = 0; k < 4; k++) mb[k] = $urandom;
        for (int r = 0; r < 20; r++) begin
            req_b = p < 8;
            we = p < 4; be = 4'hF; addr = 32'((p % 4) * 4); wdata = mb[p % 4];
            @(negedge clk);
            now = q.size() > 0 && q[0].due == r;
            n_total++; if (gnt_b !== (p < 8 && r % 4 < 2)) $display("FAIL lat4_gnt@%0d: got %b expected %b", r, gnt_b, p < 8 && r % 4 < 2); else n_pass++;
            n_total++; if (rv_b !== now) $display("FAIL lat4_rvalid@%0d: got %b expected %b", r, rv_b, now); else n_pass++;
            if (now) begin
                n_total++; if (rd_b !== q[0].rdata || err_b !== 1'b0) $display("FAIL lat4_rdata@%0d: got %h expected %h", r, rd_b, q[0].rdata); else n_pass++;
                void'(q.pop_front());
            end
            if (gnt_b) begin
                e.due = r + LAT_B; e.err = 1'b0; e.rdata = (p < 4) ? 32'h0 : mb[p % 4];
                q.push_back(e);
                p++;
            end
            step();
        end
        req_b = 1'b0;
        n_total++; if (p != 8) $display("FAIL lat4_grants: got %0d expected 8", p); else n_pass++;
`endif
    endtask

    task automatic test_reset_inflight();
        int g = 0;
        req_b = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h0; wdata = 32'h600D_F00D;
        for (int i = 0; i < 40 && g == 0; i++) begin
            @(negedge clk);
            if (gnt_b) g = 1;
            step();
        end
        req_b = 1'b0;
        repeat (6) step();
        req_b = 1'b1; we = 1'b0; g = 0;
        for (int i = 0; i < 40 && g < 2; i++) begin
            @(negedge clk);
            if (gnt_b) g++;
            step();
        end
        req_b = 1'b0;
        n_total++; if (g != 2) $display("FAIL inflight_grants: got %0d expected 2", g); else n_pass++;
        rst_nb = 1'b0;
        @(negedge clk);
        n_total++; if (rv_b !== 1'b0) $display("FAIL inflight_async: got rvalid %b expected 0", rv_b); else n_pass++;
        step();
        rst_nb = 1'b1; req_b = 1'b1; addr = 32'h0;
        @(negedge clk);
        n_total++; if (gnt_b !== 1'b1) $display("FAIL post_reset_gnt: got %b expected 1", gnt_b); else n_pass++;
        step();
        req_b = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_total++; if (rv_b !== (k == 4)) $display("FAIL post_reset_rvalid[%0d]: got %b expected %b", k, rv_b, k == 4); else n_pass++;
            if (k == 4) begin
                n_total++; if (rd_b !== 32'h600D_F00D || err_b !== 1'b0) $display("FAIL post_reset_rdata: got %h expected 600df00d", rd_b); else n_pass++;
            end
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_oor();
        test_random();
        test_lat4();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/guvm_data_mem_responder.md
# guvm_data_mem_responder

Synthesizable data-memory slave answering the core's data-memory request/grant/rvalid protocol: it grants requests, performs byte-enabled writes into an internal word array, and returns read data a fixed number of cycles later. It sits on the testbench side of the core's data port, replacing the static `data_gnt_i`/`data_rvalid_i` ties. The GUVM monitor can then observe real load/store traffic.

## Interface
Parameters:
- `MEM_DEPTH_WORDS`, 1024, number of 32-bit words; power of two, ≥ 4.
- `RESP_LATENCY`, 1, cycles from grant to `data_rvalid_o`; range 1..8.
- `MAX_OUTSTANDING`, 2, maximum granted-but-unanswered requests; range 1..8.
- `LFSR_SEED`, 16'hACE1, stall-LFSR reset value; nonzero; used only with the stall feature.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. One clock; reset is asynchronous and active-low.
- `data_req_i`  in  1  core request.
- `data_gnt_o`  out  1  grant, combinational.
- `data_we_i`  in  1  1 = write.
- `data_be_i`  in  4  byte enables.
- `data_addr_i`  in  32  byte address; bits [1:0] ignored.
- `data_wdata_i`  in  32  write data.
- `data_rvalid_o`  out  1  response valid, one cycle per granted request.
- `data_rdata_o`  out  32  read data, valid with rvalid.
- `data_err_o`  out  1  out-of-range access flag, valid with rvalid.

## Operation
- `data_gnt_o` = `data_req_i` && (outstanding < `MAX_OUTSTANDING`) && !stall && `rst_ni`.
- Request fields are sampled only in a cycle where both req and gnt are high.
- Word index = `data_addr_i[log2(MEM_DEPTH_WORDS)+1:2]`.
- Out of range means `data_addr_i` ≥ 4·`MEM_DEPTH_WORDS`.
- Granted write, in range: bytes with `be[i]`=1 are written at the clock edge ending the grant cycle. Response carries rdata 32'h0 and err 0.
- Granted read, in range: the word is captured at the grant edge. The captured value includes any write granted in an earlier cycle.
- Out of range: no array update. Response carries rdata = `ERR_RDATA` (32'hDEAD_BEEF) and err 1.
- be = 4'b0000 on a write is a legal no-op write; it is still granted and still answered.
- Outstanding counter:
  - +1 on grant, −1 on rvalid.
  - Both in the same cycle leave it unchanged.
  - It never exceeds `MAX_OUTSTANDING` and never underflows.
- Responses return strictly in grant order.
- Request-side changes while req is high without gnt have no effect.

## Timing
- Grant at edge N produces `data_rvalid_o` high during cycle N+`RESP_LATENCY`, for exactly one cycle per request.
- With `MAX_OUTSTANDING` ≥ `RESP_LATENCY`, back-to-back grants sustain one response per cycle.
- With `MAX_OUTSTANDING` < `RESP_LATENCY`, gnt drops once the counter is full. It reasserts in the cycle the oldest rvalid fires.
- Reset values: `data_gnt_o` 0, `data_rvalid_o` 0, `data_rdata_o` 0, `data_err_o` 0; outstanding 0; pipeline empty.
- Array contents are not reset.
- Reset mid-operation discards all in-flight responses; no rvalid is emitted for them.
- Writes already committed to the array remain.
- rdata/err hold their last value when rvalid is low.

## Configuration
- `GUVM_DMEM_RAND_STALL_EN` defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, reset to `LFSR_SEED`, advances every cycle.
  - stall = (lfsr[1:0] == 2'b00), which withholds gnt in that cycle.
- Undefined: stall is constant 0 and no LFSR flops exist.

## Structure
- Package `guvm_mem_pkg`:
  - `ERR_RDATA` constant.
  - `dmem_resp_t` struct {rdata[31:0], err}.
  - latency/outstanding range-check constants.
- Sub-module `guvm_resp_pipe`: a `RESP_LATENCY`-deep valid+`dmem_resp_t` shift pipeline with asynchronous active-low reset on valid bits.
- Top level holds the array, grant logic, counter and LFSR.

## Test plan
- Write addr 0x10, wdata 0x11223344, be 4'hF, then read 0x10 → rvalid 1 cycle after read grant, rdata 0x11223344, err 0.
- Write 0xAABBCCDD be 4'b0101 over 0x11223344 → subsequent read 0x11BB33DD.
- Read addr 0x1000 (depth 1024) → rdata 0xDEADBEEF, err 1, array unchanged.
- `RESP_LATENCY`=4, `MAX_OUTSTANDING`=2, req held high → gnt pattern 1,1,0,0 repeating, each rvalid 4 cycles after its grant, order preserved.
- Reset asserted with 2 reads in flight → no rvalid after release, counter 0, first new req granted immediately.
- With `GUVM_DMEM_RAND_STALL_EN`, 1000 random accesses → every granted request gets exactly one in-order response, and gnt is never high when lfsr[1:0]==0.
